// File: rtl/pio_symbol_sequencer_if.sv
// pio_symbol_sequencer_if
// Byte-stream input handshake plus the Avalon-MM write port towards the PIO.
// The master modport is the sequencer's view (it masters the PIO bus and
// consumes the byte stream); the slave modport is the environment's view.
interface pio_symbol_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output pio_address,
        output pio_chipselect,
        output pio_write_n,
        output pio_writedata
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  pio_address,
        input  pio_chipselect,
        input  pio_write_n,
        input  pio_writedata
    );
endinterface

// File: rtl/pio_symbol_sequencer.sv
// pio_symbol_sequencer
// Buffers symbol bytes in a small FIFO and writes one byte to an Avalon PIO
// every max(period,2) cycles. Optional feature macro PIO_SEQ_IDLE_PATTERN_EN:
// when defined, an idle_pattern byte is written instead of stopping whenever
// the FIFO runs dry while enabled.
module pio_symbol_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PERIOD_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [PERIOD_W-1:0]    period,
`ifdef PIO_SEQ_IDLE_PATTERN_EN
    input  logic [7:0]             idle_pattern,
`endif
    pio_symbol_sequencer_if.master bus,
    output logic                   busy,
    output logic                   underflow,
    output logic [PERIOD_W-1:0]    symbol_count
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [7:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;

    logic [1:0]          state;
    logic [7:0]          symbol;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] hold_load;

    // in_ready comes from registered occupancy only, so a same-cycle pop never raises it early
    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign push     = bus.in_valid && !full;
    assign bus.in_ready = !full;

    // HOLD lasts max(period,2)-1 cycles, giving a strobe spacing of max(period,2)
    assign hold_load = (period < PERIOD_W'(2)) ? '0 : period - PERIOD_W'(2);

    assign bus.pio_address    = 2'b00;
    assign bus.pio_chipselect = (state == WRITE);
    assign bus.pio_write_n    = (state != WRITE);
    assign bus.pio_writedata  = {24'b0, symbol};
    assign busy               = (state != IDLE);

    // Pop the FIFO head whenever the FSM is about to start a new data symbol
    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:    pop = enable && !empty;
            HOLD:    pop = (cnt == '0) && enable && !empty;
            default: pop = 1'b0;
        endcase
    end

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    // FIFO pointers and occupancy; push+pop together leaves occupancy unchanged
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Symbol FSM: IDLE -> WRITE (one strobe cycle) -> HOLD (countdown) -> WRITE/IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            symbol       <= '0;
            cnt          <= '0;
            symbol_count <= '0;
            underflow    <= 1'b0;
        end else begin
            underflow <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        symbol <= mem[rd_ptr];
                        state  <= WRITE;
                    end
                end
                WRITE: begin
                    cnt          <= hold_load;
                    symbol_count <= symbol_count + 1'b1;
                    state        <= HOLD;
                end
                HOLD: begin
                    if (cnt == '0) begin
                        if (pop) begin
                            symbol <= mem[rd_ptr];
                            state  <= WRITE;
                        end else if (enable) begin
                            underflow <= 1'b1;
`ifdef PIO_SEQ_IDLE_PATTERN_EN
                            symbol    <= idle_pattern;
                            state     <= WRITE;
`else
                            state     <= IDLE;
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pio_symbol_sequencer.sv
// tb_pio_symbol_sequencer
// Self-checking bench: table-driven bursts, hand-written corner sequences and
// randomized bursts checked against a strobe-schedule model. Build with
// PIO_SEQ_IDLE_PATTERN_EN defined to exercise idle-pattern insertion.
module tb_pio_symbol_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = 4;
`ifdef PIO_SEQ_IDLE_PATTERN_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic          clk;
    logic          reset_n;
    logic          enable;
    logic [PW-1:0] period;
    logic          busy;
    logic          underflow;
    logic [PW-1:0] symbol_count;
    logic [7:0]    idle_pat;

    pio_symbol_sequencer_if bus ();

    pio_symbol_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .PERIOD_W   (PW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .period       (period),
`ifdef PIO_SEQ_IDLE_PATTERN_EN
        .idle_pattern (idle_pat),
`endif
        .bus          (bus),
        .busy         (busy),
        .underflow    (underflow),
        .symbol_count (symbol_count)
    );

    typedef struct {
        int          c;
        logic [31:0] d;
    } strobe_t;

    typedef struct {
        int unsigned per;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        int unsigned sp;
    } vec_t;

    strobe_t sq [$];
    int      uq [$];
    int      cyc = 0;
    bit      addr_bad = 1'b0;
    int      checks = 0;
    int      failures = 0;
    int      sbase = 0;
    int      ubase = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe strobes, underflow pulses and the address bus
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.pio_chipselect && !bus.pio_write_n) begin
                sq.push_back('{cyc, bus.pio_writedata});
            end
            if (underflow) begin
                uq.push_back(cyc);
            end
            if (bus.pio_address != 2'd0) begin
                addr_bad = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int x);
        while (cyc < x) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string tag);
        int g;
        g = 0;
        @(negedge clk);
        while (busy && g < 100) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL %s idle-timeout actual=busy required=idle", tag);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        enable      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        period      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        sbase = sq.size();
        ubase = uq.size();
    endtask

    task automatic push_bytes(input logic [7:0] b[$], input int from, input int to);
        for (int i = from; i < to; i++) begin
            int  guard;
            bit  acc;
            guard = 0;
            acc   = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_data  = b[i];
            while (!acc) begin
                @(negedge clk);
                acc = bus.in_ready;
                @(posedge clk);
                #1;
                guard++;
                if (!acc && guard > 200) begin
                    checks++;
                    failures++;
                    $display("FAIL push-timeout actual=not-accepted required=accepted byte=0x%0h", b[i]);
                    acc = 1'b1;
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    // Model: strobe k at e+1+k*sp carrying byte k, one underflow sp after the last
    task automatic check_run(input string tag, input logic [7:0] b[$], input int e, input int sp);
        int n;
        int t_end;
        int ns;
        int nu;
        logic [7:0] expd;
        n     = b.size();
        t_end = e + 1 + n * sp;
        wait_cyc(t_end + 1);
        enable = 1'b0;
        wait_idle(tag);
        ns = sq.size() - sbase;
        nu = uq.size() - ubase;
        chk({tag, " strobe-count"}, ns, n + EXTRA);
        for (int k = 0; k < n + EXTRA; k++) begin
            if (k < ns) begin
                expd = (k < n) ? b[k] : idle_pat;
                chk($sformatf("%s data%0d", tag, k), sq[sbase + k].d, {24'b0, expd});
                chk($sformatf("%s cycle%0d", tag, k), sq[sbase + k].c, e + 1 + k * sp);
            end
        end
        chk({tag, " underflow-count"}, nu, 1);
        if (nu > 0) begin
            chk({tag, " underflow-cycle"}, uq[ubase], t_end);
        end
        chk({tag, " symbol_count"}, symbol_count, (n + EXTRA) % (1 << PW));
    endtask

    task automatic run_burst(input string tag, input int p, input logic [7:0] b[$], input int sp);
        int e;
        int pre;
        do_reset();
        period = PW'(p);
        pre = (b.size() < int'(DEPTH)) ? b.size() : int'(DEPTH);
        push_bytes(b, 0, pre);
        enable = 1'b1;
        e = cyc;
        push_bytes(b, pre, b.size());
        check_run(tag, b, e, sp);
    endtask

    initial begin
        vec_t       tbl [5];
        logic [7:0] q [$];
        int         e;
        int         n;
        int         p;

        idle_pat = 8'h55;
        tbl[0] = '{5, 8'hA5, 8'h3C, 8'h81, 5};
        tbl[1] = '{0, 8'h11, 8'h22, 8'h33, 2};
        tbl[2] = '{1, 8'hF0, 8'h0F, 8'hAA, 2};
        tbl[3] = '{2, 8'h01, 8'h80, 8'hFF, 2};
        tbl[4] = '{7, 8'h5A, 8'hC3, 8'h00, 7};

        // Reset state and quiet release
        reset_n      = 1'b0;
        enable       = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        period       = '0;
        @(posedge clk);
        #1;
        chk("rst in_ready", bus.in_ready, 1);
        chk("rst busy", busy, 0);
        chk("rst write_n", bus.pio_write_n, 1);
        chk("rst chipselect", bus.pio_chipselect, 0);
        chk("rst writedata", bus.pio_writedata, 0);
        chk("rst underflow", underflow, 0);
        chk("rst symbol_count", symbol_count, 0);
        @(negedge clk);
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("release no-strobe", sq.size(), 0);
        chk("release busy", busy, 0);
        chk("release in_ready", bus.in_ready, 1);
        chk("release write_n", bus.pio_write_n, 1);
        enable = 1'b0;

        // Table-driven three-byte bursts over several periods
        for (int i = 0; i < 5; i++) begin
            q = '{tbl[i].b0, tbl[i].b1, tbl[i].b2};
            run_burst($sformatf("tbl%0d", i), int'(tbl[i].per), q, int'(tbl[i].sp));
        end

        // Backpressure: fifth byte held until the first pop, order preserved
        do_reset();
        period = PW'(3);
        q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        push_bytes(q, 0, 4);
        @(negedge clk);
        chk("bp full in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h50;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp held in_ready", bus.in_ready, 0);
        chk("bp no strobe while disabled", sq.size() - sbase, 0);
        @(posedge clk);
        #1;
        enable = 1'b1;
        e = cyc;
        @(negedge clk);
        chk("bp no early ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp ready after pop", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_run("bp", q, e, 3);

        // Period change during HOLD and enable drop that must not truncate
        do_reset();
        period = PW'(6);
        q = '{8'hC1, 8'hC2, 8'hC3};
        push_bytes(q, 0, 3);
        enable = 1'b1;
        e = cyc;
        wait_cyc(e + 3);
        period = PW'(3);
        wait_cyc(e + 11);
        enable = 1'b0;
        @(negedge clk);
        chk("hold busy e+11", busy, 1);
        @(negedge clk);
        chk("hold busy e+12", busy, 1);
        @(negedge clk);
        chk("hold busy e+13", busy, 0);
        chk("hold strobe-count", sq.size() - sbase, 3);
        if (sq.size() - sbase >= 3) begin
            chk("hold cycle0", sq[sbase].c, e + 1);
            chk("hold cycle1", sq[sbase + 1].c, e + 7);
            chk("hold cycle2", sq[sbase + 2].c, e + 10);
            chk("hold data2", sq[sbase + 2].d, 32'h000000C3);
        end
        chk("hold no underflow", uq.size() - ubase, 0);
        chk("hold symbol_count", symbol_count, 3);

        // Reset pulsed mid-HOLD with three bytes still queued
        do_reset();
        period = PW'(6);
        q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        push_bytes(q, 0, 4);
        enable = 1'b1;
        e = cyc;
        wait_cyc(e + 3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst chipselect", bus.pio_chipselect, 0);
        chk("midrst write_n", bus.pio_write_n, 1);
        chk("midrst busy", busy, 0);
        chk("midrst symbol_count", symbol_count, 0);
        chk("midrst in_ready", bus.in_ready, 1);
        chk("midrst writedata", bus.pio_writedata, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        sbase = sq.size();
        ubase = uq.size();
        repeat (10) @(posedge clk);
        #1;
        chk("midrst no strobe", sq.size() - sbase, 0);
        chk("midrst count after", symbol_count, 0);
        q = '{8'h77};
        push_bytes(q, 0, 1);
        e = cyc;
        check_run("midrst new", q, e, 6);

        // Randomized bursts, including symbol_count wrap
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 20);
            p = $urandom_range(0, 6);
            q.delete();
            for (int k = 0; k < n; k++) begin
                q.push_back(8'($urandom));
            end
            run_burst($sformatf("rnd%0d", r), p, q, (p < 2) ? 2 : p);
        end

`ifdef PIO_SEQ_IDLE_PATTERN_EN
        // Idle-pattern insertion with an underflow pulse per inserted symbol
        do_reset();
        period = PW'(4);
        q = '{8'h0F};
        push_bytes(q, 0, 1);
        enable = 1'b1;
        e = cyc;
        wait_cyc(e + 14);
        enable = 1'b0;
        wait_idle("idlepat");
        chk("idlepat strobe-count", sq.size() - sbase, 4);
        chk("idlepat underflow-count", uq.size() - ubase, 3);
        for (int k = 0; k < 4; k++) begin
            if (k < sq.size() - sbase) begin
                chk($sformatf("idlepat data%0d", k), sq[sbase + k].d, (k == 0) ? 32'h0F : 32'h55);
                chk($sformatf("idlepat cycle%0d", k), sq[sbase + k].c, e + 1 + 4 * k);
            end
            if (k > 0 && k - 1 < uq.size() - ubase) begin
                chk($sformatf("idlepat ucycle%0d", k), uq[ubase + k - 1], e + 1 + 4 * k);
            end
        end
        chk("idlepat symbol_count", symbol_count, 4);
`endif

        chk("pio_address always zero", addr_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
